// File: rtl/wb_dbg_pkg.sv
// Shared opcodes, reply status codes and FSM states for the Wishbone debug master.
package wb_dbg_pkg;

    localparam logic [7:0] CMD_WRITE  = 8'h01;
    localparam logic [7:0] CMD_READ   = 8'h02;

    localparam logic [7:0] ST_ACK     = 8'hA5;
    localparam logic [7:0] ST_ERR     = 8'hE1;
    localparam logic [7:0] ST_TIMEOUT = 8'hEE;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
        BUS,
        STATUS,
        RDATA
    } state_t;

endpackage

// File: rtl/wb_dbg_master.sv
// Byte-stream driven Wishbone classic master: decodes host read/write commands,
// runs one 32-bit bus cycle per command and streams back a status byte plus read data.
module wb_dbg_master
    import wb_dbg_pkg::*;
#(
    parameter int unsigned timeout_cycles = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    input  logic        wb_ack_i,
    input  logic        wb_err_i
);

    localparam int unsigned      TMO_W    = $clog2(timeout_cycles + 1);
    // Abort on the cycle whose increment would make the count reach timeout_cycles.
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(timeout_cycles - 1);

    state_t           state;
    logic [1:0]       byte_cnt;
    logic [TMO_W-1:0] tmo_cnt;
    logic [31:0]      rdata;

    assign wb_sel_o = 4'hF;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            byte_cnt <= '0;
            tmo_cnt  <= '0;
            rdata    <= '0;
            wb_adr_o <= '0;
            wb_dat_o <= '0;
            wb_we_o  <= 1'b0;
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            tx_valid <= 1'b0;
            tx_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (rx_valid && (rx_data == CMD_WRITE || rx_data == CMD_READ)) begin
                        wb_we_o  <= (rx_data == CMD_WRITE);
                        byte_cnt <= '0;
                        state    <= ADDR;
                    end
                end

                ADDR: begin
                    if (rx_valid) begin
                        wb_adr_o <= {wb_adr_o[23:0], rx_data};
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            byte_cnt <= '0;
                            if (wb_we_o) begin
                                state <= DATA;
                            end else begin
                                wb_cyc_o <= 1'b1;
                                wb_stb_o <= 1'b1;
                                tmo_cnt  <= '0;
                                state    <= BUS;
                            end
                        end
                    end
                end

                DATA: begin
                    if (rx_valid) begin
                        wb_dat_o <= {wb_dat_o[23:0], rx_data};
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            byte_cnt <= '0;
                            wb_cyc_o <= 1'b1;
                            wb_stb_o <= 1'b1;
                            tmo_cnt  <= '0;
                            state    <= BUS;
                        end
                    end
                end

                // Err wins over ack; either wins over a timeout in the same cycle.
                BUS: begin
                    if (wb_ack_i || wb_err_i || tmo_cnt == TMO_LAST) begin
                        wb_cyc_o <= 1'b0;
                        wb_stb_o <= 1'b0;
                        tx_valid <= 1'b1;
                        byte_cnt <= '0;
                        state    <= STATUS;
                        if (wb_err_i) begin
                            tx_data <= ST_ERR;
                            rdata   <= '0;
                        end else if (wb_ack_i) begin
                            tx_data <= ST_ACK;
                            rdata   <= wb_dat_i;
                        end else begin
                            tx_data <= ST_TIMEOUT;
                            rdata   <= '0;
                        end
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end

                STATUS: begin
                    if (tx_ready) begin
                        if (wb_we_o) begin
                            tx_valid <= 1'b0;
                            state    <= IDLE;
                        end else begin
                            tx_data  <= rdata[31:24];
                            rdata    <= {rdata[23:0], 8'h00};
                            byte_cnt <= '0;
                            state    <= RDATA;
                        end
                    end
                end

                RDATA: begin
                    if (tx_ready) begin
                        if (byte_cnt == 2'd3) begin
                            tx_valid <= 1'b0;
                            state    <= IDLE;
                        end else begin
                            tx_data  <= rdata[31:24];
                            rdata    <= {rdata[23:0], 8'h00};
                            byte_cnt <= byte_cnt + 2'd1;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_dbg_master.sv
// Scoreboard bench for wb_dbg_master: a command driver queues expected bus cycles and reply
// bytes from a reference model; independent bus and tx monitors pop and compare.
module tb_wb_dbg_master;
    import wb_dbg_pkg::*;

    localparam int TMO = 8;
    localparam int K_ACK = 0, K_ERR = 1, K_BOTH = 2, K_SILENT = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_ack_i;
    logic        wb_err_i;

    wb_dbg_master #(.timeout_cycles(TMO)) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .wb_adr_o (wb_adr_o),
        .wb_dat_o (wb_dat_o),
        .wb_dat_i (wb_dat_i),
        .wb_sel_o (wb_sel_o),
        .wb_we_o  (wb_we_o),
        .wb_cyc_o (wb_cyc_o),
        .wb_stb_o (wb_stb_o),
        .wb_ack_i (wb_ack_i),
        .wb_err_i (wb_err_i)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [31:0] adr;
        logic [31:0] dat;
        logic        we;
        int          len;
    } bus_t;

    bus_t       exp_bus[$];
    logic [7:0] exp_tx[$];

    // Slave model: responds on the cur_d-th cycle of strobe according to cur_kind.
    int          cur_kind  = K_SILENT;
    int          cur_d     = 1;
    logic [31:0] cur_rdata = '0;
    int          scnt      = 0;

    always @(posedge clk) begin
        if (rst || !(wb_cyc_o && wb_stb_o)) scnt <= 0;
        else                                scnt <= scnt + 1;
    end

    assign wb_ack_i = wb_cyc_o && wb_stb_o && (cur_kind == K_ACK || cur_kind == K_BOTH) && (scnt == cur_d - 1);
    assign wb_err_i = wb_cyc_o && wb_stb_o && (cur_kind == K_ERR || cur_kind == K_BOTH) && (scnt == cur_d - 1);
    assign wb_dat_i = wb_ack_i ? cur_rdata : 32'hBAD0_BAD0;

    // Bus monitor
    bit   in_cyc = 1'b0;
    bus_t cur;
    int   blen;

    always @(negedge clk) begin
        if (wb_cyc_o) begin
            if (!in_cyc) begin
                in_cyc = 1'b1;
                blen   = 0;
                checks++;
                if (exp_bus.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_bus_cycle: adr %h we %b with no command pending", wb_adr_o, wb_we_o);
                    cur.adr = wb_adr_o;
                    cur.dat = wb_dat_o;
                    cur.we  = wb_we_o;
                    cur.len = -1;
                end else begin
                    cur = exp_bus.pop_front();
                end
            end
            blen++;
            check("bus_stb", 32'(wb_stb_o), 32'd1);
            check("bus_adr", wb_adr_o, cur.adr);
            check("bus_we", 32'(wb_we_o), 32'(cur.we));
            check("bus_sel", 32'(wb_sel_o), 32'hF);
            if (cur.we) check("bus_dat", wb_dat_o, cur.dat);
        end else if (in_cyc) begin
            in_cyc = 1'b0;
            check("bus_len", 32'(blen), 32'(cur.len));
        end
    end

    // Tx monitor and random ready source
    int         ready_pct  = 100;
    bit         prev_stall = 1'b0;
    logic [7:0] prev_data  = '0;

    always @(negedge clk) begin
        tx_ready = (int'($urandom_range(0, 99)) < ready_pct);
        if (rst) prev_stall = 1'b0;
        if (prev_stall) begin
            check("tx_hold_valid", 32'(tx_valid), 32'd1);
            check("tx_hold_data", 32'(tx_data), 32'(prev_data));
        end
        if (tx_valid && tx_ready) begin
            if (exp_tx.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_tx: got byte %h with no reply pending", tx_data);
            end else begin
                check("tx_byte", 32'(tx_data), 32'(exp_tx.pop_front()));
            end
        end
        prev_stall = tx_valid && !tx_ready && !rst;
        prev_data  = tx_data;
    end

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int k = 0;
        while ((exp_tx.size() != 0 || exp_bus.size() != 0 || in_cyc) && k < 300) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (k >= 300) begin
            errors++;
            $display("FAIL %s_drain: %0d reply bytes, %0d bus cycles pending after %0d cycles",
                     name, exp_tx.size(), exp_bus.size(), k);
            exp_tx.delete();
            exp_bus.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    // Reference model: outcome follows from which of ack/err/timeout comes first.
    task automatic run_cmd(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           input int kind, input int d, input logic [31:0] rd,
                           input bit junk_bus, input bit junk_rdata);
        logic [7:0] st;
        int         len;
        bus_t       e;
        if (kind == K_SILENT || d > TMO) begin
            st  = ST_TIMEOUT;
            len = TMO;
        end else if (kind == K_ACK) begin
            st  = ST_ACK;
            len = d;
        end else begin
            st  = ST_ERR;
            len = d;
        end
        cur_kind  = kind;
        cur_d     = d;
        cur_rdata = rd;
        e.adr = adr;
        e.dat = dat;
        e.we  = we;
        e.len = len;
        exp_bus.push_back(e);
        exp_tx.push_back(st);
        if (!we)
            for (int i = 3; i >= 0; i--) exp_tx.push_back(st == ST_ACK ? rd[8*i +: 8] : 8'h00);

        send_byte(we ? CMD_WRITE : CMD_READ);
        for (int i = 3; i >= 0; i--) send_byte(adr[8*i +: 8]);
        if (we)
            for (int i = 3; i >= 0; i--) send_byte(dat[8*i +: 8]);
        if (junk_bus) send_byte(we ? CMD_READ : CMD_WRITE);
        if (junk_rdata && !we) begin
            int k = 0;
            while (exp_tx.size() > 4 && k < 300) begin
                @(negedge clk);
                k++;
            end
            if (exp_tx.size() inside {[1:4]}) send_byte(CMD_WRITE);
        end
        wait_drain("cmd");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = '0;
        repeat (3) @(negedge clk);
        check("rst_adr", wb_adr_o, 32'h0);
        check("rst_dat", wb_dat_o, 32'h0);
        check("rst_we", 32'(wb_we_o), 32'd0);
        check("rst_cyc", 32'(wb_cyc_o), 32'd0);
        check("rst_stb", 32'(wb_stb_o), 32'd0);
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_sel", 32'(wb_sel_o), 32'hF);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Directed write and read
        run_cmd(1'b1, 32'h0000_7002, 32'hDEAD_BEEF, K_ACK, 2, 32'h0, 1'b0, 1'b0);
        ready_pct = 50;
        run_cmd(1'b0, 32'h4000_0010, 32'h0, K_ACK, 1, 32'h1234_5678, 1'b0, 1'b0);

        // Timeout boundary: silent, ack on the last allowed cycle, ack one cycle too late
        run_cmd(1'b0, 32'h0000_0100, 32'h0, K_SILENT, 1, 32'h0, 1'b0, 1'b0);
        run_cmd(1'b0, 32'h0000_0104, 32'h0, K_ACK, TMO, 32'hCAFE_F00D, 1'b0, 1'b0);
        run_cmd(1'b0, 32'h0000_0108, 32'h0, K_ACK, TMO + 1, 32'h1111_2222, 1'b0, 1'b0);

        // Error on first strobe cycle, and ack+err together
        run_cmd(1'b1, 32'h8000_0000, 32'h0BAD_F00D, K_ERR, 1, 32'h0, 1'b0, 1'b0);
        run_cmd(1'b0, 32'h8000_0004, 32'h0, K_BOTH, 3, 32'h5A5A_5A5A, 1'b0, 1'b0);

        // Garbage byte in IDLE
        send_byte(8'h55);
        repeat (6) @(negedge clk);
        check("garbage_cyc", 32'(wb_cyc_o), 32'd0);
        check("garbage_tx_valid", 32'(tx_valid), 32'd0);
        run_cmd(1'b1, 32'h0000_0055, 32'h0102_0304, K_ACK, 1, 32'h0, 1'b0, 1'b0);

        // Command bytes arriving during BUS and RDATA are dropped
        run_cmd(1'b0, 32'h2000_0000, 32'h0, K_ACK, 3, 32'h8765_4321, 1'b1, 1'b1);
        run_cmd(1'b1, 32'h2000_0004, 32'hAABB_CCDD, K_ACK, 1, 32'h0, 1'b1, 1'b0);

        // Reset mid-ADDR, then a full command
        send_byte(CMD_WRITE);
        send_byte(8'h11);
        send_byte(8'h22);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_cmd(1'b0, 32'h3333_4444, 32'h0, K_ACK, 2, 32'h9ABC_DEF0, 1'b0, 1'b0);

        // Reset during BUS: cycle ends after 3 strobe cycles, no reply
        begin
            bus_t e;
            cur_kind = K_SILENT;
            cur_d    = 1;
            e.adr = 32'h7777_0000;
            e.dat = 32'h0;
            e.we  = 1'b0;
            e.len = 3;
            exp_bus.push_back(e);
            send_byte(CMD_READ);
            for (int i = 3; i >= 0; i--) send_byte(e.adr[8*i +: 8]);
            repeat (2) @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            check("rst_bus_cyc", 32'(wb_cyc_o), 32'd0);
            repeat (TMO + 4) @(negedge clk);
            check("rst_bus_tx_valid", 32'(tx_valid), 32'd0);
            wait_drain("rst_bus");
        end

        // Randomized traffic
        for (int n = 0; n < 40; n++) begin
            int pick;
            pick = int'($urandom_range(0, 2));
            ready_pct = (pick == 0) ? 30 : (pick == 1) ? 70 : 100;
            run_cmd(1'($urandom_range(0, 1)), $urandom, $urandom,
                    int'($urandom_range(0, 3)), int'($urandom_range(1, TMO + 2)), $urandom,
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        wait_drain("final");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_dbg_master.md
# wb_dbg_master

Byte-stream-driven Wishbone master that lets a host read and write any slave on the system bus. It sits between a UART byte interface and a spare master port of the Wishbone interconnect (m2), alongside the LM32 instruction and data masters. It decodes read/write commands from received bytes, runs one 32-bit Wishbone classic cycle per command, and returns a status byte plus read data.

## Interface
Parameters:
- timeout_cycles, 255: maximum cycles a bus cycle may wait for ack/err before abort; range 1..65535.

Ports:
- clk  in  1  system clock
- rst  in  1  reset rst, synchronous, active-high; clock clk
- rx_data  in  8  received byte
- rx_valid  in  1  single-cycle strobe, rx_data valid; no backpressure
- tx_data  out  8  byte to transmit
- tx_valid  out  1  tx_data valid, held until accepted
- tx_ready  in  1  transmitter accepts byte when high together with tx_valid
- wb_adr_o  out  32  Wishbone address
- wb_dat_o  out  32  write data
- wb_dat_i  in  32  read data
- wb_sel_o  out  4  byte select, constant 4'hF
- wb_we_o  out  1  write enable
- wb_cyc_o  out  1  cycle
- wb_stb_o  out  1  strobe
- wb_ack_i  in  1  slave acknowledge
- wb_err_i  in  1  slave error

## Operation
- Command format, all multi-byte fields MSB first:
  - 0x01 write: cmd, addr[4], data[4]; reply: status.
  - 0x02 read: cmd, addr[4]; reply: status, data[4].
  - Any other first byte is discarded; FSM stays in IDLE.
- Status codes: 0xA5 ack, 0xE1 err, 0xEE timeout. Read data is 0x00000000 on err or timeout.
- States:
  - IDLE: on rx_valid, 0x01 -> ADDR (we=1); 0x02 -> ADDR (we=0).
  - ADDR: shift 4 bytes into the address register. After the 4th byte, go to DATA if write, else BUS.
  - DATA: shift 4 bytes into the write-data register, then BUS.
  - BUS: cyc=stb=1 until ack, err or timeout; then STATUS.
  - STATUS: present the status byte. When accepted, go to RDATA if read, else IDLE.
  - RDATA: present 4 data bytes, then IDLE.
- A 2-bit byte counter is shared by ADDR, DATA and RDATA and cleared on every state entry.
- rx_valid in BUS, STATUS or RDATA: byte dropped, no state effect.
- Timeout counter (width clog2(timeout_cycles+1)): cleared on BUS entry, increments each BUS cycle without ack/err.
  - Abort when the count equals timeout_cycles.
  - Ack or err in that same cycle takes priority over the timeout.
  - Ack and err asserted together are treated as err.
- Read data is captured from wb_dat_i on the ack cycle.
- Reset in any state: return to IDLE, drop the partial command and any pending reply, deassert cyc/stb in the next cycle.

## Timing
- Reset values: wb_adr_o=0, wb_dat_o=0, wb_we_o=0, wb_cyc_o=0, wb_stb_o=0, tx_valid=0, tx_data=0, wb_sel_o=4'hF.
- All outputs are registered.
- wb_cyc_o/wb_stb_o rise on the clock edge that samples the last command byte, so they are high the following cycle.
- Fall: both drop on the edge that samples ack/err/timeout. On that same edge tx_valid rises with the status byte.
- Minimum BUS duration is 1 cycle (ack in the first cycle of stb).
- wb_adr_o, wb_dat_o and wb_we_o are stable for the whole cycle.
- A tx byte transfers on an edge where tx_valid & tx_ready. The next byte is presented in the following cycle (tx_valid stays high between bytes of a reply).
- After the last reply byte transfers, the block is back in IDLE the next cycle and accepts a new command byte.

## Structure
- Package wb_dbg_pkg holds:
  - command opcodes (CMD_WRITE=8'h01, CMD_READ=8'h02),
  - status codes (ST_ACK, ST_ERR, ST_TIMEOUT),
  - the state enumeration (IDLE, ADDR, DATA, BUS, STATUS, RDATA).
- Single module: one FSM plus shift registers and a timeout counter. No sub-module.

## Test plan
- Write: bytes 01 00 00 70 02 DE AD BE EF, slave acks after 2 cycles -> one cycle with adr=0x00007002, dat=0xDEADBEEF, we=1, sel=F; reply A5.
- Read: bytes 02 40 00 00 10, slave returns 0x12345678 with ack -> reply A5 12 34 56 78; tx_ready toggled randomly, no byte lost or duplicated.
- Timeout: timeout_cycles=8, read of silent slave -> stb high exactly 8 cycles; reply EE 00 00 00 00; ack arriving exactly at cycle 8 -> A5.
- Error: write with wb_err_i on the 1st stb cycle -> reply E1; cyc drops after 1 cycle. Garbage byte 0x55 in IDLE -> ignored, no bus activity.
- Drop and reset: bytes sent during BUS and RDATA are ignored. rst asserted mid-ADDR, then a full command -> executes correctly. rst during BUS -> cyc low next cycle, no reply.
